// File: rtl/fb_port_arbiter_if.sv
// Frame RAM arbiter bus: display read port, host write port,
// bank swap control and the RAM-side port.
interface fb_port_arbiter_if #(
    parameter int ADDR_WIDTH      = 11,
    parameter int DATA_WIDTH      = 16,
    parameter int STALL_CNT_WIDTH = 8
);
    logic                       disp_req;
    logic [ADDR_WIDTH-1:0]      disp_addr;
    logic [DATA_WIDTH-1:0]      disp_data;
    logic                       disp_valid;
    logic                       wr_valid;
    logic                       wr_ready;
    logic [ADDR_WIDTH-1:0]      wr_addr;
    logic [DATA_WIDTH-1:0]      wr_data;
    logic                       frame_start;
    logic                       swap_req;
    logic                       swap_ack;
    logic [ADDR_WIDTH:0]        ram_addr;
    logic                       ram_we;
    logic [DATA_WIDTH-1:0]      ram_wdata;
    logic [DATA_WIDTH-1:0]      ram_rdata;
    logic [STALL_CNT_WIDTH-1:0] wr_stall_count;

    modport slave (
        input  disp_req, disp_addr,
        output disp_data, disp_valid,
        input  wr_valid, wr_addr, wr_data,
        output wr_ready,
        input  frame_start, swap_req,
        output swap_ack,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata,
        output wr_stall_count
    );

    modport master (
        output disp_req, disp_addr,
        input  disp_data, disp_valid,
        output wr_valid, wr_addr, wr_data,
        input  wr_ready,
        output frame_start, swap_req,
        input  swap_ack,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata,
        input  wr_stall_count
    );
endinterface

// File: rtl/fb_port_arbiter.sv
// Single-port frame RAM arbiter: display reads win, host writes drain idle cycles.
// Optional double buffering enabled by defining BANK_SWAP_EN.
module fb_port_arbiter #(
    parameter int ADDR_WIDTH      = 11,
    parameter int DATA_WIDTH      = 16,
    parameter int STALL_CNT_WIDTH = 8
) (
    input  logic               clk_in,
    input  logic               reset,
    fb_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        GNT_IDLE  = 2'd0,
        GNT_DISP  = 2'd1,
        GNT_WRITE = 2'd2
    } grant_t;

    logic                       r_pend_valid;
    logic [ADDR_WIDTH-1:0]      r_pend_addr;
    logic [DATA_WIDTH-1:0]      r_pend_data;
    logic [ADDR_WIDTH:0]        r_ram_addr;
    logic                       r_ram_we;
    logic [DATA_WIDTH-1:0]      r_ram_wdata;
    logic                       r_dv1;
    logic                       r_dv2;
    logic [STALL_CNT_WIDTH-1:0] r_stall;

    grant_t w_grant;
    logic   w_drain;
    logic   w_accept;
    logic   w_front;
    logic   w_back;
    logic   w_swap_ack;

    assign w_drain  = r_pend_valid && !bus.disp_req;
    assign w_accept = bus.wr_valid && bus.wr_ready;

    always_comb begin
        w_grant = GNT_IDLE;
        if (bus.disp_req)
            w_grant = GNT_DISP;
        else if (r_pend_valid)
            w_grant = GNT_WRITE;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= '0;
        end else begin
            r_ram_we <= 1'b0;
            case (w_grant)
                GNT_DISP: r_ram_addr <= {w_front, bus.disp_addr};
                GNT_WRITE: begin
                    r_ram_addr  <= {w_back, r_pend_addr};
                    r_ram_we    <= 1'b1;
                    r_ram_wdata <= r_pend_data;
                end
                default: ;
            endcase
        end
    end

    // A drain and an accept in the same cycle refill the buffer.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_data  <= '0;
        end else if (w_accept) begin
            r_pend_valid <= 1'b1;
            r_pend_addr  <= bus.wr_addr;
            r_pend_data  <= bus.wr_data;
        end else if (w_drain) begin
            r_pend_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_dv1   <= 1'b0;
            r_dv2   <= 1'b0;
            r_stall <= '0;
        end else begin
            r_dv1 <= bus.disp_req;
            r_dv2 <= r_dv1;
            if (r_pend_valid && bus.disp_req && !(&r_stall))
                r_stall <= r_stall + 1'b1;
        end
    end

`ifdef BANK_SWAP_EN
    logic r_front;
    logic r_swap_pend;
    logic r_swap_ack;
    logic w_swap_go;

    // Swap waits for an empty buffer so a queued write never
    // lands in the bank that has just become visible.
    assign w_swap_go = bus.frame_start && !r_pend_valid &&
                       (r_swap_pend || bus.swap_req);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_front     <= 1'b0;
            r_swap_pend <= 1'b0;
            r_swap_ack  <= 1'b0;
        end else begin
            r_swap_ack <= w_swap_go;
            if (w_swap_go) begin
                r_front     <= ~r_front;
                r_swap_pend <= 1'b0;
            end else if (bus.swap_req) begin
                r_swap_pend <= 1'b1;
            end
        end
    end

    assign w_front    = r_front;
    assign w_back     = ~r_front;
    assign w_swap_ack = r_swap_ack;
`else
    logic w_unused_swap;

    assign w_unused_swap = bus.swap_req ^ bus.frame_start;
    assign w_front       = 1'b0;
    assign w_back        = 1'b0;
    assign w_swap_ack    = 1'b0;
`endif

    assign bus.disp_data      = bus.ram_rdata;
    assign bus.disp_valid     = r_dv2;
    assign bus.wr_ready       = !r_pend_valid || w_drain;
    assign bus.swap_ack       = w_swap_ack;
    assign bus.ram_addr       = r_ram_addr;
    assign bus.ram_we         = r_ram_we;
    assign bus.ram_wdata      = r_ram_wdata;
    assign bus.wr_stall_count = r_stall;
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a behavioural frame RAM.
// Unwritten RAM words read back as their own address.
module tb_fb_port_arbiter;
    localparam int AW = 11;
    localparam int DW = 16;
    localparam int SW = 8;
    localparam int NW = 1 << (AW + 1);

`ifdef BANK_SWAP_EN
    localparam logic [AW:0]   BK = 12'h800;
    localparam logic [DW-1:0] RB = 16'h0010;
`else
    localparam logic [AW:0]   BK = 12'h000;
    localparam logic [DW-1:0] RB = 16'hBEEF;
`endif

    typedef struct {
        logic          req;
        logic [AW-1:0] da;
        logic          wv;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          rdy;
        logic          we;
        logic [AW:0]   ra;
        logic [DW-1:0] rwd;
        logic          dv;
        logic [DW-1:0] dd;
    } vec_t;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    int   total  = 0;
    int   bad    = 0;

    always #5 clk_in = ~clk_in;

    fb_port_arbiter_if #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STALL_CNT_WIDTH(SW)
    ) bus ();

    fb_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STALL_CNT_WIDTH(SW)
    ) dut (
        .clk_in(clk_in),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] mem   [NW];
    bit            wr_ok [NW];
    logic [27:0]   wlog  [$];

    initial bus.ram_rdata = '0;

    always @(posedge clk_in) begin
        if (bus.ram_we) begin
            mem[bus.ram_addr]   <= bus.ram_wdata;
            wr_ok[bus.ram_addr] <= 1'b1;
            wlog.push_back({bus.ram_addr, bus.ram_wdata});
        end
        bus.ram_rdata <= wr_ok[bus.ram_addr] ? mem[bus.ram_addr]
                                             : DW'(bus.ram_addr);
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_in();
        bus.disp_req    = 1'b0;
        bus.disp_addr   = '0;
        bus.wr_valid    = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        bus.frame_start = 1'b0;
        bus.swap_req    = 1'b0;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    vec_t tbl [9];

    initial begin
        int lowcnt;
        int n0;
        logic ev;

        tbl[0] = '{1'b0, 11'h000, 1'b1, 11'h010, 16'hBEEF,
                   1'b1, 1'b0, 12'h03F, 16'h0000, 1'b0, 16'h0000};
        tbl[1] = '{1'b0, 11'h000, 1'b0, 11'h000, 16'h0000,
                   1'b1, 1'b1, BK | 12'h010, 16'hBEEF, 1'b0, 16'h0000};
        tbl[2] = '{1'b1, 11'h010, 1'b0, 11'h000, 16'h0000,
                   1'b1, 1'b0, 12'h010, 16'h0000, 1'b0, 16'h0000};
        tbl[3] = '{1'b0, 11'h000, 1'b0, 11'h000, 16'h0000,
                   1'b1, 1'b0, 12'h010, 16'h0000, 1'b1, RB};
        tbl[4] = '{1'b0, 11'h000, 1'b1, 11'h020, 16'h1111,
                   1'b1, 1'b0, 12'h010, 16'h0000, 1'b0, 16'h0000};
        tbl[5] = '{1'b0, 11'h000, 1'b1, 11'h021, 16'h2222,
                   1'b1, 1'b1, BK | 12'h020, 16'h1111, 1'b0, 16'h0000};
        tbl[6] = '{1'b1, 11'h030, 1'b1, 11'h022, 16'h3333,
                   1'b0, 1'b0, 12'h030, 16'h0000, 1'b0, 16'h0000};
        tbl[7] = '{1'b0, 11'h000, 1'b0, 11'h000, 16'h0000,
                   1'b1, 1'b1, BK | 12'h021, 16'h2222, 1'b1, 16'h0030};
        tbl[8] = '{1'b0, 11'h000, 1'b0, 11'h000, 16'h0000,
                   1'b1, 1'b0, BK | 12'h021, 16'h0000, 1'b0, 16'h0000};

        // reset held, then released with no traffic
        idle_in();
        repeat (3) tick();
        chk("rst_ready", bus.wr_ready, 1);
        chk("rst_we", bus.ram_we, 0);
        reset = 1'b0;
        lowcnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.ram_we !== 1'b0) lowcnt++;
        end
        chk("idle_we_never", lowcnt, 0);
        chk("idle_addr", bus.ram_addr, 0);
        chk("idle_wdata", bus.ram_wdata, 0);
        chk("idle_dv", bus.disp_valid, 0);
        chk("idle_ddata", bus.disp_data, 0);
        chk("idle_ack", bus.swap_ack, 0);
        chk("idle_stall", bus.wr_stall_count, 0);
        chk("idle_ready", bus.wr_ready, 1);

        // 64-cycle display burst
        for (int k = 0; k < 67; k++) begin
            bus.disp_req  = (k < 64);
            bus.disp_addr = (k < 64) ? AW'(k) : '0;
            tick();
            if (k < 64) chk("burst_addr", bus.ram_addr, k);
            ev = (k >= 1 && k <= 64);
            chk("burst_valid", bus.disp_valid, ev);
            if (ev) chk("burst_data", bus.disp_data, k - 1);
        end

        // table: single write, readback, drain+accept overlap
        foreach (tbl[i]) begin
            bus.disp_req  = tbl[i].req;
            bus.disp_addr = tbl[i].da;
            bus.wr_valid  = tbl[i].wv;
            bus.wr_addr   = tbl[i].wa;
            bus.wr_data   = tbl[i].wd;
            #1;
            chk($sformatf("v%0d_ready", i), bus.wr_ready, tbl[i].rdy);
            tick();
            chk($sformatf("v%0d_we", i), bus.ram_we, tbl[i].we);
            chk($sformatf("v%0d_addr", i), bus.ram_addr, tbl[i].ra);
            chk($sformatf("v%0d_dv", i), bus.disp_valid, tbl[i].dv);
            if (tbl[i].dv)
                chk($sformatf("v%0d_dd", i), bus.disp_data, tbl[i].dd);
            if (tbl[i].we)
                chk($sformatf("v%0d_wd", i), bus.ram_wdata, tbl[i].rwd);
        end
        chk("tbl_stall", bus.wr_stall_count, 1);

        // writes during a 64-cycle burst
        do_reset();
        chk("rst2_stall", bus.wr_stall_count, 0);
        wlog.delete();
        bus.disp_req  = 1'b1;
        bus.disp_addr = '0;
        bus.wr_valid  = 1'b1;
        bus.wr_addr   = 11'h040;
        bus.wr_data   = 16'hAAAA;
        #1;
        chk("bw_first_ready", bus.wr_ready, 1);
        tick();
        lowcnt = 0;
        for (int i = 1; i < 64; i++) begin
            bus.disp_addr = AW'(i);
            bus.wr_addr   = 11'h041;
            bus.wr_data   = 16'hBBBB;
            #1;
            if (bus.wr_ready !== 1'b0) lowcnt++;
            tick();
        end
        chk("bw_ready_low", lowcnt, 0);
        chk("bw_no_write", wlog.size(), 0);
        bus.disp_req = 1'b0;
        #1;
        chk("bw_end_ready", bus.wr_ready, 1);
        tick();
        bus.wr_valid = 1'b0;
        tick();
        tick();
        chk("bw_stall", bus.wr_stall_count, 63);
        chk("bw_nwrites", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("bw_w0", wlog[0], {BK | 12'h040, 16'hAAAA});
            chk("bw_w1", wlog[1], {BK | 12'h041, 16'hBBBB});
        end

        // stall counter saturation
        bus.disp_req = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 11'h060;
        bus.wr_data  = 16'h5555;
        tick();
        bus.wr_valid = 1'b0;
        repeat (300) tick();
        chk("sat_stall", bus.wr_stall_count, 255);
        chk("sat_ready", bus.wr_ready, 0);
        bus.disp_req = 1'b0;
        tick();
        tick();
        chk("sat_drain", wlog[$], {BK | 12'h060, 16'h5555});
        chk("sat_hold", bus.wr_stall_count, 255);

        // reset during a drain cancels the write
        n0 = wlog.size();
        bus.disp_req = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 11'h070;
        bus.wr_data  = 16'hCCCC;
        tick();
        idle_in();
        reset = 1'b1;
        tick();
        chk("rd_we", bus.ram_we, 0);
        chk("rd_stall", bus.wr_stall_count, 0);
        reset = 1'b0;
        tick();
        tick();
        chk("rd_discard", wlog.size(), n0);
        chk("rd_ready", bus.wr_ready, 1);

`ifdef BANK_SWAP_EN
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 11'h005;
        bus.wr_data  = 16'h1234;
        tick();
        bus.wr_valid = 1'b0;
        tick();
        chk("sw_waddr", bus.ram_addr, 12'h805);
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        tick();
        chk("sw_no_early_ack", bus.swap_ack, 0);
        bus.frame_start = 1'b1;
        tick();
        chk("sw_ack", bus.swap_ack, 1);
        bus.frame_start = 1'b0;
        tick();
        chk("sw_ack_pulse", bus.swap_ack, 0);
        bus.disp_req  = 1'b1;
        bus.disp_addr = 11'h005;
        tick();
        chk("sw_raddr", bus.ram_addr, 12'h805);
        bus.disp_req = 1'b0;
        tick();
        chk("sw_dv", bus.disp_valid, 1);
        chk("sw_data", bus.disp_data, 16'h1234);

        // deferred swap: write pending at frame_start
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req  = 1'b0;
        bus.disp_req  = 1'b1;
        bus.disp_addr = '0;
        bus.wr_valid  = 1'b1;
        bus.wr_addr   = 11'h006;
        bus.wr_data   = 16'h7777;
        tick();
        bus.wr_valid    = 1'b0;
        bus.frame_start = 1'b1;
        tick();
        chk("def_no_ack", bus.swap_ack, 0);
        bus.frame_start = 1'b0;
        bus.disp_req    = 1'b0;
        tick();
        chk("def_waddr", bus.ram_addr, 12'h006);
        chk("def_still_no_ack", bus.swap_ack, 0);
        bus.frame_start = 1'b1;
        tick();
        chk("def_ack", bus.swap_ack, 1);
        bus.frame_start = 1'b0;
        bus.disp_req    = 1'b1;
        bus.disp_addr   = 11'h006;
        tick();
        chk("def_raddr", bus.ram_addr, 12'h006);
        bus.disp_req = 1'b0;
        tick();
        chk("def_data", bus.disp_data, 16'h7777);

        // swap_req together with frame_start
        bus.swap_req    = 1'b1;
        bus.frame_start = 1'b1;
        tick();
        chk("same_ack", bus.swap_ack, 1);
        idle_in();
        tick();
        chk("same_ack_pulse", bus.swap_ack, 0);
`else
        lowcnt = 0;
        bus.wr_valid    = 1'b1;
        bus.wr_addr     = 11'h005;
        bus.wr_data     = 16'h1234;
        bus.swap_req    = 1'b1;
        tick();
        if (bus.swap_ack !== 1'b0) lowcnt++;
        idle_in();
        bus.frame_start = 1'b1;
        tick();
        if (bus.swap_ack !== 1'b0) lowcnt++;
        chk("ns_waddr", bus.ram_addr, 12'h005);
        bus.frame_start = 1'b0;
        tick();
        if (bus.swap_ack !== 1'b0) lowcnt++;
        chk("ns_ack_never", lowcnt, 0);
        bus.disp_req  = 1'b1;
        bus.disp_addr = 11'h005;
        tick();
        chk("ns_raddr", bus.ram_addr, 12'h005);
        bus.disp_req = 1'b0;
        tick();
        chk("ns_dv", bus.disp_valid, 1);
        chk("ns_data", bus.disp_data, 16'h1234);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
